// File: rtl/modn_ctr_seq_pkg.sv
// Shared definitions for the mod-N counter sequencer: FSM state encoding
// and the default datapath geometry.
package modn_ctr_seq_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int N_DEFAULT_DEF = 10;
  localparam int WRAPW_DEF     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/modn_ctr_seq_core.sv
// Counter core: a WIDTH-bit count register that wraps at mod-1, with a
// synchronous clear that takes priority over the count enable.
import modn_ctr_seq_pkg::*;

module modn_ctr_seq_core #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  // Wrap decode straight off the registered count, so tc has no extra latency.
  assign tc = (out == mod - WIDTH'(1));

  // Count register: clear wins, otherwise advance and wrap when enabled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (en) begin
      out <= tc ? '0 : out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/modn_ctr_seq.sv
// Sequencer for the mod-N counter: accepts configuration in IDLE, runs,
// pauses and stops the core, counts wraps and pulses done at run end.
import modn_ctr_seq_pkg::*;

module modn_ctr_seq #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int N_DEFAULT = N_DEFAULT_DEF,
  parameter int WRAPW     = WRAPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic [WRAPW-1:0] cfg_wraps,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [WIDTH-1:0] mod_r;
  logic [WRAPW-1:0] wraps_r;
  logic [WRAPW-1:0] wrap_cnt;
  logic             core_en, core_clr, core_tc;
  logic             run_wrap, wrap_last;

  modn_ctr_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (core_en),
    .clr (core_clr),
    .mod (mod_r),
    .out (out),
    .tc  (core_tc)
  );

  // A terminal-count edge that actually advances the counter in RUN.
  assign run_wrap  = (state == ST_RUN) && !stop && !pause && core_tc;
  // This wrap completes the programmed run (never true when free-running).
  assign wrap_last = (wraps_r != '0) && (wrap_cnt == wraps_r - WRAPW'(1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: stop beats pause beats counting.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (stop)                       state_next = ST_IDLE;
        else if (pause)                 state_next = ST_HOLD;
        else if (run_wrap && wrap_last) state_next = ST_DONE;
      end
      ST_HOLD: begin
        if (stop)        state_next = ST_IDLE;
        else if (!pause) state_next = ST_RUN;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode and core control; the core is held clear outside a live run.
  always_comb begin
    cfg_ready = (state == ST_IDLE);
    busy      = (state == ST_RUN) || (state == ST_HOLD);
    done      = (state == ST_DONE);
    tc        = (state == ST_RUN) && core_tc;
    core_en   = (state == ST_RUN) && !stop && !pause;
    core_clr  = (state == ST_IDLE) || (state_next == ST_IDLE) || (state_next == ST_DONE);
  end

  // Configuration registers: load only on an accepted offer; illegal moduli fall back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_r   <= WIDTH'(N_DEFAULT);
      wraps_r <= '0;
    end else if (cfg_valid && cfg_ready) begin
      mod_r   <= (cfg_mod < WIDTH'(2)) ? WIDTH'(N_DEFAULT) : cfg_mod;
      wraps_r <= cfg_wraps;
    end
  end

  // Wrap counter: cleared at start, saturating so a free run never rolls over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      wrap_cnt <= '0;
    end else if (run_wrap && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + WRAPW'(1);
    end
  end

endmodule

// File: tb/tb_modn_ctr_seq.sv
// Self-checking bench for modn_ctr_seq: table vectors, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_modn_ctr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [3:0] cfg_mod;
  logic [7:0] cfg_wraps;
  logic       start, pause, stop;
  logic [3:0] out;
  logic       tc, busy, done;

  int checks = 0;
  int errors = 0;

  modn_ctr_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mod(cfg_mod), .cfg_wraps(cfg_wraps), .start(start), .pause(pause),
    .stop(stop), .out(out), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model: run phase, modulus, target wraps, count, wraps seen.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mphase_t;
  mphase_t m_phase;
  int m_n, m_w, m_cnt, m_seen;

  typedef struct {
    logic       cv; logic [3:0] cm; logic [7:0] cw; logic st, pa, sp;
    logic [3:0] eo; logic et, eb, ed, er;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE; m_n = 10; m_w = 0; m_cnt = 0; m_seen = 0;
  endtask

  task automatic model_step();
    case (m_phase)
      M_IDLE: begin
        if (cfg_valid) begin
          m_n = (cfg_mod < 2) ? 10 : int'(cfg_mod);
          m_w = int'(cfg_wraps);
        end
        if (start) begin m_phase = M_RUN; m_cnt = 0; m_seen = 0; end
      end
      M_RUN: begin
        if (stop) begin m_phase = M_IDLE; m_cnt = 0; end
        else if (pause) m_phase = M_HOLD;
        else if (m_cnt == m_n - 1) begin
          m_cnt = 0;
          if (m_seen < 255) m_seen++;
          if (m_w != 0 && m_seen == m_w) m_phase = M_DONE;
        end else m_cnt++;
      end
      M_HOLD: begin
        if (stop) begin m_phase = M_IDLE; m_cnt = 0; end
        else if (!pause) m_phase = M_RUN;
      end
      M_DONE: begin m_phase = M_IDLE; m_cnt = 0; end
    endcase
  endtask

  task automatic check_model();
    check("out",       int'(out),       m_cnt);
    check("tc",        int'(tc),        int'(m_phase == M_RUN && m_cnt == m_n - 1));
    check("busy",      int'(busy),      int'(m_phase == M_RUN || m_phase == M_HOLD));
    check("done",      int'(done),      int'(m_phase == M_DONE));
    check("cfg_ready", int'(cfg_ready), int'(m_phase == M_IDLE));
  endtask

  task automatic drive(input logic cv, input logic [3:0] cm, input logic [7:0] cw,
                       input logic st, input logic pa, input logic sp);
    cfg_valid = cv; cfg_mod = cm; cfg_wraps = cw; start = st; pause = pa; stop = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_model();
  endtask

  initial begin
    // Mod-5 two-wrap run, cfg_valid during RUN ignored, start during DONE ignored.
    vecs[0]  = '{1'b1, 4'd5, 8'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset: held low two cycles, outputs at reset values without any edge.
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;

    // Default free run: out 0..9 repeating, tc only at 9.
    drive(1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 1; i < 25; i++) begin
      tick();
      check("free_out", int'(out), i % 10);
      check("free_tc", int'(tc), int'(i % 10 == 9));
    end
    stop = 1'b1; tick(); stop = 1'b0;
    tick();

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].cv, vecs[i].cm, vecs[i].cw, vecs[i].st, vecs[i].pa, vecs[i].sp);
      tick();
      check($sformatf("vec%0d_out", i),  int'(out),       int'(vecs[i].eo));
      check($sformatf("vec%0d_tc", i),   int'(tc),        int'(vecs[i].et));
      check($sformatf("vec%0d_busy", i), int'(busy),      int'(vecs[i].eb));
      check($sformatf("vec%0d_done", i), int'(done),      int'(vecs[i].ed));
      check($sformatf("vec%0d_rdy", i),  int'(cfg_ready), int'(vecs[i].er));
    end

    // Pause at out=3 for four cycles, then resume from the held value.
    drive(1'b1, 4'd10, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_out", int'(out), 3);
      check("hold_tc", int'(tc), 0);
    end
    pause = 1'b0;
    tick(); check("resume_out0", int'(out), 3);
    tick(); check("resume_out1", int'(out), 4);
    tick(); check("resume_out2", int'(out), 5);
    tick(); check("pre_stop_out", int'(out), 6);

    // Stop and pause together at out=6: stop wins, no done.
    pause = 1'b1; stop = 1'b1;
    tick();
    check("stop_out", int'(out), 0);
    check("stop_busy", int'(busy), 0);
    check("stop_rdy", int'(cfg_ready), 1);
    pause = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stop_nodone", int'(done), 0);
    end

    // Asynchronous reset mid-run at out=7 with mod=12, then default mod restored.
    drive(1'b1, 4'd12, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    check("pre_rst_out", int'(out), 7);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_out", int'(out), 0);
    check("arst_busy", int'(busy), 0);
    check_model();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    check("revert_tc_out", int'(out), 9);
    check("revert_tc", int'(tc), 1);
    tick();
    check("revert_wrap", int'(out), 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // cfg_mod=1 falls back to 10; offers during RUN refused, one-wrap run ends.
    drive(1'b1, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd3, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      check("busy_rdy", int'(cfg_ready), 0);
    end
    check("n10_out", int'(out), 9);
    cfg_valid = 1'b0;
    tick();
    check("n10_done", int'(done), 1);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(3) == 0), 4'($urandom_range(15)), 8'($urandom_range(3)),
            ($urandom_range(3) == 0), ($urandom_range(5) == 0), ($urandom_range(15) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
